// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: multiply/divide FSM
// state encodings, ID_md_op codes and the register-match helper.
package hazard_ctrl_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [1:0] MD_OP_NONE = 2'b00;
  localparam logic [1:0] MD_OP_MUL  = 2'b01;
  localparam logic [1:0] MD_OP_DIV  = 2'b10;

  localparam int CNT_W   = 6;
  localparam int STALL_W = 16;

  // Conservative: either source field counts as a read, and $0 never matches.
  function automatic logic regMatch(input logic [4:0] r,
                                    input logic [4:0] rs,
                                    input logic [4:0] rt);
    return (r != 5'd0) && ((r == rs) || (r == rt));
  endfunction

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch-operand stalls, control-flow
// flushes and sequencing of the multi-cycle multiply/divide unit.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic [4:0]   ID_rs,
  input  logic [4:0]   ID_rt,
  input  logic         ID_branch,
  input  logic         ID_jump,
  input  logic [1:0]   ID_md_op,
  input  logic         ID_md_use,
  input  logic [4:0]   EXE_num_write,
  input  logic         EXE_reg_write,
  input  logic         EXE_mem_read,
  input  logic         EXE_branch_taken,
  input  logic [4:0]   MEM_num_write,
  input  logic         MEM_mem_read,
  output logic         pc_en,
  output logic         if_id_en,
  output logic         if_id_flush,
  output logic         id_exe_flush,
  output logic         md_start,
  output logic         md_busy,
  output logic         md_done,
  output logic [15:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  md_state_e          r_mdState;
  md_state_e          w_mdStateNext;
  logic [CNT_W-1:0]   r_mdCnt;
  logic [CNT_W-1:0]   w_mdCntNext;
  logic [STALL_W-1:0] r_stallCnt;

  logic w_exeMatch;
  logic w_memMatch;
  logic w_loadUse;
  logic w_branchDep;
  logic w_mdReq;
  logic w_mdConflict;
  logic w_stall;
  logic w_issue;
  logic w_mdLast;

  assign w_exeMatch   = regMatch(EXE_num_write, ID_rs, ID_rt);
  assign w_memMatch   = regMatch(MEM_num_write, ID_rs, ID_rt);
  assign w_loadUse    = EXE_mem_read && w_exeMatch;
  assign w_branchDep  = ID_branch &&
                        ((EXE_reg_write && w_exeMatch) || (MEM_mem_read && w_memMatch));
  assign w_mdReq      = (ID_md_op == MD_OP_MUL) || (ID_md_op == MD_OP_DIV);
  assign md_busy      = (r_mdState == MD_BUSY);
  // Conflict stays asserted through the done cycle; HI/LO are only valid afterwards.
  assign w_mdConflict = md_busy && (ID_md_use || w_mdReq);
  assign w_stall      = w_loadUse || w_branchDep || w_mdConflict;
  assign w_issue      = (r_mdState == MD_IDLE) && w_mdReq && !w_stall && !EXE_branch_taken;
  assign w_mdLast     = md_busy && (r_mdCnt == '0);
  assign stall_cnt    = r_stallCnt;

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_exe_flush = 1'b0;
    md_start     = 1'b0;
    md_done      = 1'b0;
    if (!rst_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_exe_flush = 1'b1;
    end else begin
      md_start = w_issue;
      md_done  = w_mdLast;
      if (EXE_branch_taken) begin
        if_id_flush  = 1'b1;
        id_exe_flush = 1'b1;
      end else if (w_stall) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_exe_flush = 1'b1;
      end else if (ID_jump) begin
        if_id_flush  = 1'b1;
      end
    end
  end

  // A taken branch never cancels a running operation: its issuer is older.
  always_comb begin
    w_mdStateNext = r_mdState;
    w_mdCntNext   = r_mdCnt;
    case (r_mdState)
      MD_IDLE: begin
        if (w_issue) begin
          w_mdStateNext = MD_BUSY;
          w_mdCntNext   = (ID_md_op == MD_OP_MUL) ? MUL_LOAD : DIV_LOAD;
        end
      end
      MD_BUSY: begin
        if (r_mdCnt == '0) begin
          w_mdStateNext = MD_IDLE;
        end else begin
          w_mdCntNext = r_mdCnt - 1'b1;
        end
      end
      default: begin
        w_mdStateNext = MD_IDLE;
        w_mdCntNext   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_mdState <= MD_IDLE;
      r_mdCnt   <= '0;
    end else begin
      r_mdState <= w_mdStateNext;
      r_mdCnt   <= w_mdCntNext;
    end
  end

  // Only cycles actually held by a stall count; a flush-overridden stall does not.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_stallCnt <= '0;
    end else if (w_stall && !EXE_branch_taken && (r_stallCnt != {STALL_W{1'b1}})) begin
      r_stallCnt <= r_stallCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_hazard_ctrl;

  logic        clock;
  logic        rst_n;
  logic [4:0]  ID_rs, ID_rt;
  logic        ID_branch, ID_jump;
  logic [1:0]  ID_md_op;
  logic        ID_md_use;
  logic [4:0]  EXE_num_write;
  logic        EXE_reg_write, EXE_mem_read, EXE_branch_taken;
  logic [4:0]  MEM_num_write;
  logic        MEM_mem_read;
  logic        pc_en, if_id_en, if_id_flush, id_exe_flush;
  logic        md_start, md_busy, md_done;
  logic [15:0] stall_cnt;

  hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clock(clock), .rst_n(rst_n),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_branch(ID_branch), .ID_jump(ID_jump),
    .ID_md_op(ID_md_op), .ID_md_use(ID_md_use),
    .EXE_num_write(EXE_num_write), .EXE_reg_write(EXE_reg_write),
    .EXE_mem_read(EXE_mem_read), .EXE_branch_taken(EXE_branch_taken),
    .MEM_num_write(MEM_num_write), .MEM_mem_read(MEM_mem_read),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_exe_flush(id_exe_flush), .md_start(md_start), .md_busy(md_busy),
    .md_done(md_done), .stall_cnt(stall_cnt)
  );

  // {pc_en, if_id_en, if_id_flush, id_exe_flush}
  localparam logic [3:0] CTL_N = 4'b1100;
  localparam logic [3:0] CTL_S = 4'b0001;
  localparam logic [3:0] CTL_T = 4'b1111;
  localparam logic [3:0] CTL_J = 4'b1110;
  localparam logic [3:0] CTL_R = 4'b0011;

  typedef struct {
    string       name;
    logic [3:0]  ctl;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   sc         = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input exp_t e);
    logic [22:0] act, req;
    act = {pc_en, if_id_en, if_id_flush, id_exe_flush, md_start, md_busy, md_done, stall_cnt};
    req = {e.ctl, e.start, e.busy, e.done, e.cnt};
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got ctl=%b start=%b busy=%b done=%b cnt=%h, required ctl=%b start=%b busy=%b done=%b cnt=%h",
               e.name, act[22:19], act[18], act[17], act[16], act[15:0],
               e.ctl, e.start, e.busy, e.done, e.cnt);
    end
  endtask

  always @(negedge clock) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  // Advance one cycle and return every input to a quiet, out-of-reset value.
  task automatic applyStimulus();
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    ID_rs = 5'd0; ID_rt = 5'd0; ID_branch = 1'b0; ID_jump = 1'b0;
    ID_md_op = 2'b00; ID_md_use = 1'b0;
    EXE_num_write = 5'd0; EXE_reg_write = 1'b0; EXE_mem_read = 1'b0;
    EXE_branch_taken = 1'b0; MEM_num_write = 5'd0; MEM_mem_read = 1'b0;
  endtask

  task automatic expectOutput(input string name, input logic [3:0] ctl, input logic start,
                              input logic busy, input logic done, input logic [15:0] cnt);
    exp_t e;
    e.name = name; e.ctl = ctl; e.start = start; e.busy = busy; e.done = done; e.cnt = cnt;
    expQ.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    ID_rs = 5'd0; ID_rt = 5'd0; ID_branch = 1'b0; ID_jump = 1'b0;
    ID_md_op = 2'b00; ID_md_use = 1'b0;
    EXE_num_write = 5'd0; EXE_reg_write = 1'b0; EXE_mem_read = 1'b0;
    EXE_branch_taken = 1'b0; MEM_num_write = 5'd0; MEM_mem_read = 1'b0;
    repeat (2) @(posedge clock);

    // Reset outputs dominate even with a pending hazard and mul request
    applyStimulus();
    rst_n = 1'b0; ID_md_op = 2'b01; ID_rs = 5'd5; EXE_mem_read = 1'b1; EXE_num_write = 5'd5;
    expectOutput("reset", CTL_R, 1'b0, 1'b0, 1'b0, 16'd0);

    applyStimulus();
    expectOutput("idle", CTL_N, 1'b0, 1'b0, 1'b0, 16'd0);

    // Load-use through rs, then rt; $0 and non-load writers never stall
    applyStimulus();
    ID_rs = 5'd5; EXE_mem_read = 1'b1; EXE_reg_write = 1'b1; EXE_num_write = 5'd5;
    expectOutput("loaduse_rs", CTL_S, 1'b0, 1'b0, 1'b0, 16'd0);
    applyStimulus();
    expectOutput("loaduse_release", CTL_N, 1'b0, 1'b0, 1'b0, 16'd1);
    applyStimulus();
    ID_rt = 5'd5; EXE_mem_read = 1'b1; EXE_num_write = 5'd5;
    expectOutput("loaduse_rt", CTL_S, 1'b0, 1'b0, 1'b0, 16'd1);
    applyStimulus();
    EXE_mem_read = 1'b1; EXE_num_write = 5'd0;
    expectOutput("loaduse_r0", CTL_N, 1'b0, 1'b0, 1'b0, 16'd2);
    applyStimulus();
    ID_rs = 5'd7; EXE_reg_write = 1'b1; EXE_num_write = 5'd7;
    expectOutput("alu_nobranch", CTL_N, 1'b0, 1'b0, 1'b0, 16'd2);
    applyStimulus();
    ID_jump = 1'b1;
    expectOutput("jump", CTL_J, 1'b0, 1'b0, 1'b0, 16'd2);

    // Load -> branch: two stall cycles
    applyStimulus();
    ID_branch = 1'b1; ID_rs = 5'd8; EXE_mem_read = 1'b1; EXE_reg_write = 1'b1; EXE_num_write = 5'd8;
    expectOutput("ldbr_1", CTL_S, 1'b0, 1'b0, 1'b0, 16'd2);
    applyStimulus();
    ID_branch = 1'b1; ID_rs = 5'd8; MEM_mem_read = 1'b1; MEM_num_write = 5'd8;
    expectOutput("ldbr_2", CTL_S, 1'b0, 1'b0, 1'b0, 16'd3);
    applyStimulus();
    ID_branch = 1'b1; ID_rs = 5'd8;
    expectOutput("ldbr_go", CTL_N, 1'b0, 1'b0, 1'b0, 16'd4);

    // ALU -> branch: one stall cycle
    applyStimulus();
    ID_branch = 1'b1; ID_rs = 5'd8; EXE_reg_write = 1'b1; EXE_num_write = 5'd8;
    expectOutput("alubr_1", CTL_S, 1'b0, 1'b0, 1'b0, 16'd4);
    applyStimulus();
    ID_branch = 1'b1; ID_rs = 5'd8; MEM_num_write = 5'd8;
    expectOutput("alubr_go", CTL_N, 1'b0, 1'b0, 1'b0, 16'd5);
    sc = 5;

    // Divide then mfhi: 32 busy cycles, done on the last, released after
    applyStimulus();
    ID_md_op = 2'b10;
    expectOutput("div_issue", CTL_N, 1'b1, 1'b0, 1'b0, 16'(sc));
    for (int k = 1; k <= 32; k++) begin
      applyStimulus();
      ID_md_use = 1'b1;
      expectOutput($sformatf("div_busy%0d", k), CTL_S, 1'b0, 1'b1, (k == 32), 16'(sc));
      sc++;
    end
    applyStimulus();
    ID_md_use = 1'b1;
    expectOutput("div_release", CTL_N, 1'b0, 1'b0, 1'b0, 16'(sc));

    // Taken branch beats load-use and a mul request; nothing issues, no count
    applyStimulus();
    EXE_branch_taken = 1'b1; ID_rs = 5'd5; EXE_mem_read = 1'b1; EXE_num_write = 5'd5; ID_md_op = 2'b01;
    expectOutput("taken_prio", CTL_T, 1'b0, 1'b0, 1'b0, 16'(sc));
    applyStimulus();
    expectOutput("taken_noissue", CTL_N, 1'b0, 1'b0, 1'b0, 16'(sc));

    // Mul survives a taken branch; a second md op while busy stalls
    applyStimulus();
    ID_md_op = 2'b01;
    expectOutput("mul_issue", CTL_N, 1'b1, 1'b0, 1'b0, 16'(sc));
    applyStimulus();
    EXE_branch_taken = 1'b1; ID_md_use = 1'b1;
    expectOutput("mul_taken", CTL_T, 1'b0, 1'b1, 1'b0, 16'(sc));
    applyStimulus();
    ID_md_op = 2'b10;
    expectOutput("mul_conflict", CTL_S, 1'b0, 1'b1, 1'b0, 16'(sc));
    sc++;
    applyStimulus();
    expectOutput("mul_busy3", CTL_N, 1'b0, 1'b1, 1'b0, 16'(sc));
    applyStimulus();
    expectOutput("mul_done", CTL_N, 1'b0, 1'b1, 1'b1, 16'(sc));
    applyStimulus();
    expectOutput("mul_idle", CTL_N, 1'b0, 1'b0, 1'b0, 16'(sc));

    // Reset on cycle 3 of a mul aborts it and clears the counter
    applyStimulus();
    ID_md_op = 2'b01;
    expectOutput("abort_issue", CTL_N, 1'b1, 1'b0, 1'b0, 16'(sc));
    applyStimulus();
    expectOutput("abort_c1", CTL_N, 1'b0, 1'b1, 1'b0, 16'(sc));
    applyStimulus();
    expectOutput("abort_c2", CTL_N, 1'b0, 1'b1, 1'b0, 16'(sc));
    applyStimulus();
    rst_n = 1'b0;
    expectOutput("abort_rst", CTL_R, 1'b0, 1'b1, 1'b0, 16'(sc));
    applyStimulus();
    expectOutput("abort_after", CTL_N, 1'b0, 1'b0, 1'b0, 16'd0);

    // Saturation: 65535 stalls fill the counter, further stalls hold it
    for (int i = 0; i < 65535; i++) begin
      applyStimulus();
      ID_rs = 5'd9; EXE_mem_read = 1'b1; EXE_num_write = 5'd9;
    end
    applyStimulus();
    ID_rs = 5'd9; EXE_mem_read = 1'b1; EXE_num_write = 5'd9;
    expectOutput("sat_full", CTL_S, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    applyStimulus();
    ID_rs = 5'd9; EXE_mem_read = 1'b1; EXE_num_write = 5'd9;
    expectOutput("sat_hold", CTL_S, 1'b0, 1'b0, 1'b0, 16'hFFFF);
    applyStimulus();
    expectOutput("sat_idle", CTL_N, 1'b0, 1'b0, 1'b0, 16'hFFFF);

    for (int w = 0; w < 10 && expQ.size() > 0; w++) @(negedge clock);
    #1;
    if (expQ.size() > 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, 4, multiply latency in cycles (>=2).
REQ-002 SHALL have parameter DIV_CYCLES, 32, divide latency in cycles (>=2, <=63).
REQ-003 SHALL have port clock  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port ID_rs  in  5  rs field of instruction in ID.
REQ-006 SHALL have port ID_rt  in  5  rt field of instruction in ID.
REQ-007 SHALL have port ID_branch  in  1  ID instruction is a conditional branch that compares operands in ID.
REQ-008 SHALL have port ID_jump  in  1  ID instruction is an unconditional jump.
REQ-009 SHALL have port ID_md_op  in  2  multiply/divide issue request from ID: 00 none, 01 mul, 10 div, 11 treated as none.
REQ-010 SHALL have port ID_md_use  in  1  ID instruction reads HI/LO.
REQ-011 SHALL have port EXE_num_write  in  5  destination register of instruction in EXE.
REQ-012 SHALL have port EXE_reg_write  in  1  EXE instruction writes a register.
REQ-013 SHALL have port EXE_mem_read  in  1  EXE instruction is a load.
REQ-014 SHALL have port EXE_branch_taken  in  1  branch resolved taken in EXE.
REQ-015 SHALL have port MEM_num_write  in  5  destination register of instruction in MEM.
REQ-016 SHALL have port MEM_mem_read  in  1  MEM instruction is a load.
REQ-017 SHALL have port pc_en  out  1  PC update enable.
REQ-018 SHALL have port if_id_en  out  1  IF/ID register load enable.
REQ-019 SHALL have port if_id_flush  out  1  IF/ID register cleared to NOP.
REQ-020 SHALL have port id_exe_flush  out  1  ID/EXE register loaded with bubble.
REQ-021 SHALL have port md_start  out  1  one-cycle pulse: multiply/divide unit begins operation.
REQ-022 SHALL have port md_busy  out  1  multiply/divide operation in progress.
REQ-023 SHALL have port md_done  out  1  one-cycle pulse: HI/LO written at end of this cycle.
REQ-024 SHALL have port stall_cnt  out  16  saturating count of stall cycles since reset.

Function
REQ-025 SHALL define match(r) = r!=0 && (r==ID_rs || r==ID_rt); no register-used qualifiers, conservative.
REQ-026 SHALL raise load_use = EXE_mem_read && match(EXE_num_write).
REQ-027 SHALL raise branch_dep = ID_branch && ((EXE_reg_write && match(EXE_num_write)) || (MEM_mem_read && match(MEM_num_write))); load->branch thus stalls 2 cycles, ALU->branch 1.
REQ-028 SHALL raise md_conflict = md_busy && (ID_md_use || ID_md_op is 01/10).
REQ-029 SHALL compute outputs combinationally from inputs and registered state, priority: (1) EXE_branch_taken: pc_en=1, if_id_en=1, if_id_flush=1, id_exe_flush=1; (2) stall = load_use|branch_dep|md_conflict: pc_en=0, if_id_en=0, if_id_flush=0, id_exe_flush=1; (3) ID_jump: pc_en=1, if_id_en=1, if_id_flush=1, id_exe_flush=0; (4) otherwise pc_en=1, if_id_en=1, flushes 0.
REQ-030 SHALL implement MD FSM: MD_IDLE, MD_BUSY; md_busy=1 exactly in MD_BUSY.
REQ-031 SHALL issue when state MD_IDLE, ID_md_op is 01/10, no stall, no EXE_branch_taken: md_start=1 that cycle, next state MD_BUSY, 6-bit cnt loaded MUL_CYCLES-1 (01) or DIV_CYCLES-1 (10).
REQ-032 SHALL in MD_BUSY decrement cnt each cycle; when cnt==0 assert md_done that cycle and return to MD_IDLE next cycle; md_conflict holds through the md_done cycle.
REQ-033 SHALL not abort an operation in MD_BUSY on EXE_branch_taken (issuing instruction is older).
REQ-034 SHALL increment stall_cnt in every cycle with priority-(2) stall, saturating at 16'hFFFF.

Reset
REQ-035 SHALL, on rising edge with rst_n=0, set MD_IDLE, cnt=0, stall_cnt=0, aborting any operation in progress.
REQ-036 SHALL, while rst_n=0, drive pc_en=0, if_id_en=0, if_id_flush=1, id_exe_flush=1, md_start=0, md_done=0.

Structure
REQ-037 SHALL place MD_IDLE/MD_BUSY encodings and ID_md_op codes in the shared pipeline package.
REQ-038 SHALL be one flat module; no sub-module.

Verification
REQ-039 SHALL cover: EXE load writes $5, ID rs=5 -> 1 cycle pc_en=0, id_exe_flush=1; stall_cnt 0->1.
REQ-040 SHALL cover: ID_branch rs=8, EXE load to $8 -> 2 stall cycles; same with ALU writer of $8 -> 1 stall cycle.
REQ-041 SHALL cover: div issued (ID_md_op=10), then mfhi in ID -> md_start 1 cycle, md_busy 32 cycles, md_done on the 32nd, stall released the next cycle.
REQ-042 SHALL cover: EXE_branch_taken with simultaneous load_use and ID_md_op=01 -> both flushes 1, pc_en=1, no md_start, stall_cnt unchanged.
REQ-043 SHALL cover: rst_n=0 at cycle 3 of a mul -> md_busy=0 next cycle; stall_cnt saturation held at 16'hFFFF.
